// File: rtl/fifo_dc_rd_stream_if.sv
// Signal bundle between the dual-clock FIFO read port, the read-side adapter
// and the downstream stream consumer. The master view belongs to the adapter.
interface fifo_dc_rd_stream_if #(
    parameter int unsigned DTA_WIDTH = 8
);
    // FIFO read port
    logic                 fifo_rd_en;
    logic [DTA_WIDTH-1:0] fifo_dout;
    logic                 fifo_valid;
    logic                 fifo_empty;
    logic                 fifo_underflow;
    // Downstream stream
    logic [DTA_WIDTH-1:0] m_data;
    logic                 m_valid;
    logic                 m_ready;

    modport master (
        output fifo_rd_en,
        input  fifo_dout,
        input  fifo_valid,
        input  fifo_empty,
        input  fifo_underflow,
        output m_data,
        output m_valid,
        input  m_ready
    );

    modport slave (
        input  fifo_rd_en,
        output fifo_dout,
        output fifo_valid,
        output fifo_empty,
        output fifo_underflow,
        input  m_data,
        input  m_valid,
        output m_ready
    );
endinterface

// File: rtl/fifo_dc_rd_stream.sv
// Read-side adapter for the dual-clock FIFO. Hides the FIFO's one-cycle read
// latency behind a small circular output buffer and presents a valid/ready
// stream. Reads are issued on credit: buffered words plus the word in flight,
// less the word leaving this cycle, must stay below the buffer depth.
module fifo_dc_rd_stream #(
    parameter int unsigned DTA_WIDTH = 8,
    parameter int unsigned OUT_DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    fifo_dc_rd_stream_if.master        bus_io,
    input  logic                       flush_i,
    output logic [2:0]                 level_o,
    output logic                       err_o
);
    localparam int unsigned PtrW = (OUT_DEPTH > 2) ? 2 : 1;
    typedef logic [PtrW-1:0] ptr_t;

    logic [DTA_WIDTH-1:0] mem_q [OUT_DEPTH];
    logic [2:0]           occ_q, occ_d;
    ptr_t                 wr_ptr_q, wr_ptr_d;
    ptr_t                 rd_ptr_q, rd_ptr_d;
    logic                 inflight_q, inflight_d;
    logic                 discard_q, discard_d;
    logic                 err_q, err_d;

    logic                 pop;
    logic                 push;
    logic                 rd_en;
    logic [3:0]           committed;

    // Stream outputs, credit check and the read request
    always_comb begin
        bus_io.m_valid = (occ_q != 3'd0);
        bus_io.m_data  = mem_q[rd_ptr_q];
        pop            = bus_io.m_valid & bus_io.m_ready;
        // pop implies occ_q >= 1, so this never wraps below zero
        committed      = {1'b0, occ_q} + {3'b000, inflight_q} - {3'b000, pop};
        rd_en          = !rst && !flush_i && !bus_io.fifo_empty
                         && (committed < 4'(OUT_DEPTH));
        // A word returning from a read issued before a flush must not land
        push           = bus_io.fifo_valid & inflight_q & !discard_q & !flush_i;
        bus_io.fifo_rd_en = rd_en;
        level_o        = occ_q;
        err_o          = err_q;
    end

    // Next-state for occupancy, pointers, in-flight tracking and the error flag
    always_comb begin
        occ_d      = occ_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        inflight_d = rd_en;
        discard_d  = flush_i & inflight_q;
        err_d      = err_q | bus_io.fifo_underflow
                     | (bus_io.fifo_valid & !inflight_q)
                     | (inflight_q & !bus_io.fifo_valid);
        if (flush_i) begin
            occ_d    = 3'd0;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (push) begin
                wr_ptr_d = (wr_ptr_q == ptr_t'(OUT_DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_d = (rd_ptr_q == ptr_t'(OUT_DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
            end
            case ({push, pop})
                2'b10:   occ_d = occ_q + 3'd1;
                2'b01:   occ_d = occ_q - 3'd1;
                default: occ_d = occ_q;
            endcase
        end
    end

    // Control state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            occ_q      <= 3'd0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            inflight_q <= 1'b0;
            discard_q  <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            occ_q      <= occ_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            inflight_q <= inflight_d;
            discard_q  <= discard_d;
            err_q      <= err_d;
        end
    end

    // Buffer storage; cleared on reset so m_data reads zero until data arrives
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(OUT_DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else if (push) begin
            mem_q[wr_ptr_q] <= bus_io.fifo_dout;
        end
    end
endmodule
